// File: rtl/spike_event_pipe_fifo.sv
// Spike/frame event FIFO in the ti_clk domain feeding okBTPipeOut: synchronises slow
// spike and sim_clk pulses, pushes neuron IDs and frame markers. Optional macro SPIKE_FIFO_TIMESTAMP_EN.
module spike_event_pipe_fifo #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset_global,
  input  logic                  clear,
  input  logic                  spike_in,
  input  logic [15:0]           spkid_in,
  input  logic                  frame_in,
  input  logic                  rd_en,
  output logic [15:0]           dout,
  output logic                  ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [15:0]           drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] BLOCK_LEVEL = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);
  localparam logic [DEPTH_LOG2:0] COUNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  // clear synchroniser: only reset_global clears it, so the flush follows the synced level
  logic clear_s1, clear_s2;
  logic flush;

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      clear_s1 <= 1'b0;
      clear_s2 <= 1'b0;
    end else begin
      clear_s1 <= clear;
      clear_s2 <= clear_s1;
    end
  end

  assign flush = clear_s2;

  // Input synchronisers and edge detectors
  logic        spike_s1, spike_s2, spike_prev;
  logic        frame_s1, frame_s2, frame_prev;
  logic [15:0] spkid_s1, spkid_s2;
  logic        spike_edge, frame_edge;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      spike_s1   <= 1'b0;
      spike_s2   <= 1'b0;
      spike_prev <= 1'b0;
      frame_s1   <= 1'b0;
      frame_s2   <= 1'b0;
      frame_prev <= 1'b0;
      spkid_s1   <= '0;
      spkid_s2   <= '0;
    end else if (flush) begin
      spike_s1   <= 1'b0;
      spike_s2   <= 1'b0;
      spike_prev <= 1'b0;
      frame_s1   <= 1'b0;
      frame_s2   <= 1'b0;
      frame_prev <= 1'b0;
      spkid_s1   <= '0;
      spkid_s2   <= '0;
    end else begin
      spike_s1   <= spike_in;
      spike_s2   <= spike_s1;
      spike_prev <= spike_s2;
      frame_s1   <= frame_in;
      frame_s2   <= frame_s1;
      frame_prev <= frame_s2;
      spkid_s1   <= spkid_in;
      spkid_s2   <= spkid_s1;
    end
  end

  assign spike_edge = spike_s2 & ~spike_prev;
  assign frame_edge = frame_s2 & ~frame_prev;

  logic [15:0] marker_word;

`ifdef SPIKE_FIFO_TIMESTAMP_EN
  logic [11:0] frame_cnt;

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      frame_cnt <= '0;
    end else if (flush) begin
      frame_cnt <= '0;
    end else if (frame_edge) begin
      frame_cnt <= frame_cnt + 12'd1;
    end
  end

  assign marker_word = {4'hF, frame_cnt};
`else
  assign marker_word = 16'hFFFF;
`endif

  // Push arbitration: marker wins the write port, a coincident spike waits one cycle
  logic        pending_valid;
  logic [15:0] pending_id;
  logic        push_req;
  logic [15:0] push_data;
  logic        pending_set, pending_clr;

  always_comb begin
    push_req    = 1'b0;
    push_data   = '0;
    pending_set = 1'b0;
    pending_clr = 1'b0;
    if (frame_edge) begin
      push_req    = 1'b1;
      push_data   = marker_word;
      pending_set = spike_edge;
    end else if (pending_valid) begin
      push_req    = 1'b1;
      push_data   = pending_id;
      pending_clr = 1'b1;
    end else if (spike_edge) begin
      push_req    = 1'b1;
      push_data   = spkid_s2;
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      pending_valid <= 1'b0;
      pending_id    <= '0;
    end else if (flush) begin
      pending_valid <= 1'b0;
      pending_id    <= '0;
    end else if (pending_set) begin
      pending_valid <= 1'b1;
      pending_id    <= spkid_s2;
    end else if (pending_clr) begin
      pending_valid <= 1'b0;
    end
  end

  // FIFO control: a pop in the same cycle frees the slot for a push at full
  logic                  empty, full;
  logic                  pop, push_ok, push_drop, wr_en;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [15:0]           mem [DEPTH];

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign pop       = rd_en & ~empty;
  assign push_ok   = push_req & (~full | pop);
  assign push_drop = push_req & full & ~pop;
  assign wr_en     = push_ok & ~flush;

  // NOTE: the storage array has no reset so it maps onto block RAM; count and pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      ready     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drop_cnt  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      ready     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      ready <= (count >= BLOCK_LEVEL);

      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end else if (rd_en) begin
        dout      <= '0;
        underflow <= 1'b1;
      end

      case ({push_ok, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase

      if (push_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule
